// File: rtl/rf32_alu_core.sv
// rtl/rf32_alu_core.sv - 32-entry register file feeding four parallel ALU blocks
// Blocks: 0 arithmetic, 1 logic, 2 left shift, 3 right shift; regs 30/31 are live inputs.
module rf32_alu_core #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                          clk_i,
  input  logic                          arst_i,
  input  logic [3:0][ADDRESS_WIDTH-1:0] select_a_i,
  input  logic [3:0][ADDRESS_WIDTH-1:0] select_b_i,
  input  logic [1:0][ADDRESS_WIDTH-1:0] select_c_i,
  input  logic [3:0][ADDRESS_WIDTH-1:0] select_r_i,
  input  logic [3:0]                    enable_writing_i,
  input  logic [WORD_WIDTH-1:0]         main_input_i,
  input  logic [WORD_WIDTH-1:0]         inst_input_i,
  input  logic [1:0]                    AB_op_i,
  input  logic [1:0]                    LB_op_i,
  input  logic [1:0]                    LSB_op_i,
  input  logic [1:0]                    RSB_op_i,
  input  logic [1:0]                    select_flags_i,
  input  logic                          cf_i,
  output logic [1:0][WORD_WIDTH-1:0]    c_o,
  output logic                          cf_o,
  output logic                          zf_o,
  output logic                          of_o,
  output logic                          sf_o,
  output logic                          pf_o
);

  localparam int W          = WORD_WIDTH;
  localparam int SHW        = $clog2(WORD_WIDTH);
  localparam int NUM_STORED = 30;

  logic [31:0][W-1:0] view;
  logic [3:0][W-1:0]  blk_res;
  logic [3:0]         blk_cf;

  logic [W-1:0] ab_a, ab_b, lb_a, lb_b, ls_a, rs_a;
  logic [SHW-1:0] ls_n, rs_n;
  logic [W-1:0] ab_res, lb_res, ls_res, rs_res;
  logic [W:0]   ab_sum;
  logic         ab_cf, ab_of, ls_cf, rs_cf;
  logic [W-1:0] sel_res;

  // Each stored entry resolves its own write; later blocks override earlier ones.
  for (genvar i = 0; i < NUM_STORED; i++) begin : g_reg
    logic [W-1:0] q;
    logic         we;
    logic [W-1:0] wd;

    always_comb begin
      we = 1'b0;
      wd = '0;
      for (int k = 0; k < 4; k++) begin
        if (enable_writing_i[k] && (select_r_i[k] == ADDRESS_WIDTH'(i))) begin
          we = 1'b1;
          wd = blk_res[k];
        end
      end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
        q <= '0;
      end else if (we) begin
        q <= wd;
      end
    end

    assign view[i] = q;
  end

  assign view[30] = main_input_i;
  assign view[31] = inst_input_i;

  assign c_o[0] = view[select_c_i[0]];
  assign c_o[1] = view[select_c_i[1]];

  assign ab_a = view[select_a_i[0]];
  assign ab_b = view[select_b_i[0]];
  assign lb_a = view[select_a_i[1]];
  assign lb_b = view[select_b_i[1]];
  assign ls_a = view[select_a_i[2]];
  assign ls_n = view[select_b_i[2]][SHW-1:0];
  assign rs_a = view[select_a_i[3]];
  assign rs_n = view[select_b_i[3]][SHW-1:0];

  // Bit W of the 33-bit sum is carry-out for adds and borrow for subtracts.
  always_comb begin
    ab_sum = '0;
    case (AB_op_i)
      2'd0:    ab_sum = {1'b0, ab_a} + {1'b0, ab_b};
      2'd1:    ab_sum = {1'b0, ab_a} + {1'b0, ab_b} + {{W{1'b0}}, cf_i};
      2'd2:    ab_sum = {1'b0, ab_a} - {1'b0, ab_b};
      default: ab_sum = {1'b0, ab_a} - {1'b0, ab_b} - {{W{1'b0}}, cf_i};
    endcase
    ab_res = ab_sum[W-1:0];
    ab_cf  = ab_sum[W];
    if (AB_op_i[1]) begin
      ab_of = (ab_a[W-1] != ab_b[W-1]) && (ab_res[W-1] != ab_a[W-1]);
    end else begin
      ab_of = (ab_a[W-1] == ab_b[W-1]) && (ab_res[W-1] != ab_a[W-1]);
    end
  end

  always_comb begin
    lb_res = '0;
    case (LB_op_i)
      2'd0:    lb_res = lb_a & lb_b;
      2'd1:    lb_res = lb_a | lb_b;
      2'd2:    lb_res = lb_a ^ lb_b;
      default: lb_res = ~lb_a;
    endcase
  end

  // Carry is bit W-n of A; a shift by the full width yields 0 when n is 0.
  always_comb begin
    ls_res = '0;
    case (LSB_op_i)
      2'd0:    ls_res = ls_a << ls_n;
      2'd1:    ls_res = W'(({ls_a, ls_a} << ls_n) >> W);
      2'd2:    ls_res = ~((~ls_a) << ls_n);
      default: ls_res = W'(({ls_a, c_o[0][W-2:0]} << ls_n) >> (W - 1));
    endcase
    ls_cf = 1'({1'b0, ls_a} >> (W - int'(ls_n)));
  end

  always_comb begin
    rs_res = '0;
    case (RSB_op_i)
      2'd0:    rs_res = rs_a >> rs_n;
      2'd1:    rs_res = W'($signed(rs_a) >>> rs_n);
      2'd2:    rs_res = W'({rs_a, rs_a} >> rs_n);
      default: rs_res = W'({c_o[1][W-2:0], rs_a} >> rs_n);
    endcase
    rs_cf = 1'({rs_a, 1'b0} >> rs_n);
  end

  assign blk_res = {rs_res, ls_res, lb_res, ab_res};
  assign blk_cf  = {rs_cf, ls_cf, 1'b0, ab_cf};

  assign sel_res = blk_res[select_flags_i];
  assign cf_o    = blk_cf[select_flags_i];
  assign of_o    = (select_flags_i == 2'd0) ? ab_of : 1'b0;
  assign zf_o    = (sel_res == '0);
  assign sf_o    = sel_res[W-1];
  assign pf_o    = ~^sel_res;

endmodule

// File: tb/tb_rf32_alu_core.sv
// tb/tb_rf32_alu_core.sv - directed self-checking bench for rf32_alu_core
module tb_rf32_alu_core;

  logic             clk = 1'b0;
  logic             arst = 1'b0;
  logic [3:0][4:0]  sel_a, sel_b, sel_r;
  logic [1:0][4:0]  sel_c;
  logic [3:0]       en;
  logic [31:0]      main_in, inst_in;
  logic [1:0]       ab_op, lb_op, lsb_op, rsb_op, sel_flags;
  logic             cf_in;
  logic [1:0][31:0] c;
  logic             cf, zf, of, sf, pf;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_v [4];
  logic        exp_c [4];

  rf32_alu_core #(.WORD_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk_i(clk), .arst_i(arst),
    .select_a_i(sel_a), .select_b_i(sel_b), .select_c_i(sel_c), .select_r_i(sel_r),
    .enable_writing_i(en), .main_input_i(main_in), .inst_input_i(inst_in),
    .AB_op_i(ab_op), .LB_op_i(lb_op), .LSB_op_i(lsb_op), .RSB_op_i(rsb_op),
    .select_flags_i(sel_flags), .cf_i(cf_in), .c_o(c),
    .cf_o(cf), .zf_o(zf), .of_o(of), .sf_o(sf), .pf_o(pf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] addr, input logic [31:0] val);
    main_in = val;
    lb_op = 2'd1;
    sel_a[1] = 5'd30;
    sel_b[1] = 5'd30;
    sel_r[1] = addr;
    en = 4'b0010;
    tick();
    en = 4'b0000;
  endtask

  task automatic test_reset();
    sel_c[0] = 5'd0; sel_c[1] = 5'd1;
    lb_op = 2'd0; sel_a[1] = 5'd0; sel_b[1] = 5'd1; sel_flags = 2'd1;
    #1 arst = 1'b1;
    #2;
    n_checks++; if (c[0] !== 32'd0) begin n_fail++; $display("FAIL reset_c0: got %h expected %h", c[0], 32'd0); end
    n_checks++; if (c[1] !== 32'd0) begin n_fail++; $display("FAIL reset_c1: got %h expected %h", c[1], 32'd0); end
    n_checks++; if (zf !== 1'b1) begin n_fail++; $display("FAIL reset_zf: got %b expected 1", zf); end
    n_checks++; if (pf !== 1'b1) begin n_fail++; $display("FAIL reset_pf: got %b expected 1", pf); end
    main_in = 32'hA5A5A5A5; sel_c[1] = 5'd30;
    #1;
    n_checks++; if (c[1] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL reset_reg30: got %h expected %h", c[1], 32'hA5A5A5A5); end
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic test_add();
    main_in = 32'd1; inst_in = 32'd2;
    ab_op = 2'd0; sel_a[0] = 5'd30; sel_b[0] = 5'd31; sel_r[0] = 5'd0;
    en = 4'b0001; sel_c[0] = 5'd0; sel_flags = 2'd0; cf_in = 1'b0;
    #1;
    n_checks++; if (c[0] !== 32'd0) begin n_fail++; $display("FAIL add_no_bypass: got %h expected %h", c[0], 32'd0); end
    tick();
    en = 4'b0000;
    n_checks++; if (c[0] !== 32'd3) begin n_fail++; $display("FAIL add_result: got %h expected %h", c[0], 32'd3); end
    n_checks++; if (zf !== 1'b0) begin n_fail++; $display("FAIL add_zf: got %b expected 0", zf); end
    n_checks++; if (cf !== 1'b0) begin n_fail++; $display("FAIL add_cf: got %b expected 0", cf); end
  endtask

  task automatic test_arith_flags();
    sel_a[0] = 5'd1; sel_b[0] = 5'd31; ab_op = 2'd2; sel_r[0] = 5'd2; sel_c[0] = 5'd2;
    #1;
    n_checks++; if ({cf, sf, of, zf} !== 4'b1100) begin n_fail++; $display("FAIL sub_flags cf/sf/of/zf: got %b expected 1100", {cf, sf, of, zf}); end
    en = 4'b0001; tick(); en = 4'b0000;
    n_checks++; if (c[0] !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL sub_result: got %h expected %h", c[0], 32'hFFFFFFFE); end
    ab_op = 2'd3; cf_in = 1'b1;
    #1;
    n_checks++; if ({cf, pf} !== 2'b10) begin n_fail++; $display("FAIL sbb_flags cf/pf: got %b expected 10", {cf, pf}); end
    main_in = 32'hFFFFFFFF; inst_in = 32'd1; sel_a[0] = 5'd30; ab_op = 2'd1;
    #1;
    n_checks++; if ({cf, of, zf} !== 3'b100) begin n_fail++; $display("FAIL adc_flags cf/of/zf: got %b expected 100", {cf, of, zf}); end
    en = 4'b0001; tick(); en = 4'b0000;
    n_checks++; if (c[0] !== 32'd1) begin n_fail++; $display("FAIL adc_result: got %h expected %h", c[0], 32'd1); end
    main_in = 32'h7FFFFFFF; ab_op = 2'd0; cf_in = 1'b0;
    #1;
    n_checks++; if ({cf, of, sf} !== 3'b011) begin n_fail++; $display("FAIL add_ovf cf/of/sf: got %b expected 011", {cf, of, sf}); end
    main_in = 32'hFFFFFFFF;
    #1;
    n_checks++; if ({cf, of, zf, pf} !== 4'b1011) begin n_fail++; $display("FAIL add_wrap cf/of/zf/pf: got %b expected 1011", {cf, of, zf, pf}); end
  endtask

  task automatic test_logic();
    main_in = 32'hF0F0F0F0; inst_in = 32'h0FF00FF0; cf_in = 1'b1;
    sel_a[1] = 5'd30; sel_b[1] = 5'd31; sel_r[1] = 5'd10; sel_c[0] = 5'd10; sel_flags = 2'd1;
    exp_v = '{32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00, 32'h0F0F0F0F};
    for (int op = 0; op < 4; op++) begin
      lb_op = 2'(op);
      #1;
      n_checks++; if ({cf, of} !== 2'b00) begin n_fail++; $display("FAIL logic_op%0d cf/of: got %b expected 00", op, {cf, of}); end
      en = 4'b0010; tick(); en = 4'b0000;
      n_checks++; if (c[0] !== exp_v[op]) begin n_fail++; $display("FAIL logic_op%0d: got %h expected %h", op, c[0], exp_v[op]); end
    end
    cf_in = 1'b0;
  endtask

  task automatic test_left_shift();
    load(5'd3, 32'h90000001);
    load(5'd4, 32'hFFFFFFE4);
    load(5'd5, 32'hF0000000);
    sel_a[2] = 5'd3; sel_b[2] = 5'd4; sel_c[0] = 5'd5; sel_c[1] = 5'd6; sel_r[2] = 5'd6; sel_flags = 2'd2;
    exp_v = '{32'h00000010, 32'h00000019, 32'h0000001F, 32'h0000001E};
    for (int op = 0; op < 4; op++) begin
      lsb_op = 2'(op);
      #1;
      n_checks++; if ({cf, of} !== 2'b10) begin n_fail++; $display("FAIL lshift_op%0d cf/of: got %b expected 10", op, {cf, of}); end
      en = 4'b0100; tick(); en = 4'b0000;
      n_checks++; if (c[1] !== exp_v[op]) begin n_fail++; $display("FAIL lshift_op%0d: got %h expected %h", op, c[1], exp_v[op]); end
    end
    lsb_op = 2'd0; sel_b[2] = 5'd9;
    #1;
    n_checks++; if ({cf, sf} !== 2'b01) begin n_fail++; $display("FAIL lshift_n0 cf/sf: got %b expected 01", {cf, sf}); end
  endtask

  task automatic test_right_shift();
    load(5'd7, 32'h80000000);
    sel_a[3] = 5'd7; sel_b[3] = 5'd4; sel_c[1] = 5'd3; sel_r[3] = 5'd8; sel_c[0] = 5'd8; sel_flags = 2'd3;
    exp_v = '{32'h08000000, 32'hF8000000, 32'h08000000, 32'h18000000};
    for (int op = 0; op < 4; op++) begin
      rsb_op = 2'(op);
      #1;
      n_checks++; if ({cf, of} !== 2'b00) begin n_fail++; $display("FAIL rshift_op%0d cf/of: got %b expected 00", op, {cf, of}); end
      en = 4'b1000; tick(); en = 4'b0000;
      n_checks++; if (c[0] !== exp_v[op]) begin n_fail++; $display("FAIL rshift_op%0d: got %h expected %h", op, c[0], exp_v[op]); end
    end
    rsb_op = 2'd0; sel_a[3] = 5'd3; sel_b[3] = 5'd3;
    #1;
    n_checks++; if ({cf, zf} !== 2'b10) begin n_fail++; $display("FAIL rshift_n1 cf/zf: got %b expected 10", {cf, zf}); end
    sel_b[3] = 5'd9;
    #1;
    n_checks++; if ({cf, sf} !== 2'b01) begin n_fail++; $display("FAIL rshift_n0 cf/sf: got %b expected 01", {cf, sf}); end
  endtask

  task automatic test_collision();
    main_in = 32'h00000011;
    ab_op = 2'd0; sel_a[0] = 5'd30; sel_b[0] = 5'd9; sel_r[0] = 5'd5;
    rsb_op = 2'd0; sel_a[3] = 5'd7; sel_b[3] = 5'd4; sel_r[3] = 5'd5;
    sel_c[0] = 5'd5;
    en = 4'b1001; tick(); en = 4'b0000;
    n_checks++; if (c[0] !== 32'h08000000) begin n_fail++; $display("FAIL collision_blk3_wins: got %h expected %h", c[0], 32'h08000000); end
    en = 4'b0001; tick(); en = 4'b0000;
    n_checks++; if (c[0] !== 32'h00000011) begin n_fail++; $display("FAIL collision_blk0_alone: got %h expected %h", c[0], 32'h00000011); end
  endtask

  task automatic test_reg30_write();
    main_in = 32'h12345678; inst_in = 32'hCAFEF00D;
    lb_op = 2'd3; sel_a[1] = 5'd30; sel_r[1] = 5'd30;
    ab_op = 2'd0; sel_a[0] = 5'd30; sel_b[0] = 5'd30; sel_r[0] = 5'd31;
    sel_c[0] = 5'd30; sel_c[1] = 5'd31;
    en = 4'b0011; tick(); en = 4'b0000;
    n_checks++; if (c[0] !== 32'h12345678) begin n_fail++; $display("FAIL reg30_write_ignored: got %h expected %h", c[0], 32'h12345678); end
    n_checks++; if (c[1] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL reg31_write_ignored: got %h expected %h", c[1], 32'hCAFEF00D); end
  endtask

  task automatic test_async_reset();
    main_in = 32'hDEADBEEF;
    sel_c[0] = 5'd7; sel_c[1] = 5'd30;
    sel_flags = 2'd3; rsb_op = 2'd0; sel_a[3] = 5'd7; sel_b[3] = 5'd4;
    #1;
    n_checks++; if (c[0] !== 32'h80000000) begin n_fail++; $display("FAIL areset_pre: got %h expected %h", c[0], 32'h80000000); end
    #1 arst = 1'b1;
    #1;
    n_checks++; if (c[0] !== 32'd0) begin n_fail++; $display("FAIL areset_clear: got %h expected %h", c[0], 32'd0); end
    n_checks++; if (c[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL areset_reg30: got %h expected %h", c[1], 32'hDEADBEEF); end
    n_checks++; if (zf !== 1'b1) begin n_fail++; $display("FAIL areset_zf: got %b expected 1", zf); end
    lb_op = 2'd1; sel_a[1] = 5'd30; sel_b[1] = 5'd30; sel_r[1] = 5'd7;
    en = 4'b0010;
    tick();
    n_checks++; if (c[0] !== 32'd0) begin n_fail++; $display("FAIL areset_write_blocked: got %h expected %h", c[0], 32'd0); end
    @(negedge clk);
    arst = 1'b0;
    #1;
    n_checks++; if (c[0] !== 32'd0) begin n_fail++; $display("FAIL areset_release_no_edge: got %h expected %h", c[0], 32'd0); end
    tick();
    en = 4'b0000;
    n_checks++; if (c[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL areset_write_resumes: got %h expected %h", c[0], 32'hDEADBEEF); end
  endtask

  initial begin
    sel_a = '0; sel_b = '0; sel_r = '0; sel_c = '0; en = '0;
    main_in = '0; inst_in = '0;
    ab_op = '0; lb_op = '0; lsb_op = '0; rsb_op = '0; sel_flags = '0; cf_in = 1'b0;
    test_reset();
    test_add();
    test_arith_flags();
    test_logic();
    test_left_shift();
    test_right_shift();
    test_collision();
    test_reg30_write();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
